// File: rtl/mini_mips_multicycle.sv
// Multi-cycle 16-bit-instruction MiniMIPS core: FETCH/DECODE/EXEC/MEM/WB.
// Ports: clk, rst_n (sync, low), instr/instr_valid/instr_ready, pc,
// result/result_valid, illegal. Owns 8-entry regfile and data memory.
module mini_mips_multicycle #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 6,
  parameter int DMEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              illegal
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int AW   = $clog2(DMEM_DEPTH);

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ANDI = 4'h2;
  localparam logic [3:0] OP_ORI  = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_BNE  = 4'h7;
  localparam logic [3:0] OP_SLTI = 4'h8;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t state, state_nx;

  logic [15:0]       ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr, result_q;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [3:0]        op;
  logic [2:0]        rs, rt, rd, funct;
  logic [DATA_W-1:0] imm_ext, opnd, alu_res;
  logic [DATA_W-1:0] rd_rs, rd_rt, wb_val;
  logic [2:0]        wb_dst;
  logic [AW-1:0]     maddr;
  logic              legal, is_br, is_mem;
  logic              taken, lt;

  assign op      = ir[15:12];
  assign rs      = ir[11:9];
  assign rt      = ir[8:6];
  assign rd      = ir[5:3];
  assign funct   = ir[2:0];
  assign imm_ext = {{(DATA_W-6){ir[5]}}, ir[5:0]};

  assign legal  = (op <= OP_SLTI);
  assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign taken  = ((op == OP_BEQ) && (a == b)) ||
                  ((op == OP_BNE) && (a != b));

  assign rd_rs  = (rs == 3'd0) ? '0 : regs[rs];
  assign rd_rt  = (rt == 3'd0) ? '0 : regs[rt];
  assign maddr  = alu_out[AW-1:0];
  assign wb_val = (op == OP_LW) ? mdr : alu_out;
  assign wb_dst = (op == OP_R) ? rd : rt;

  always_comb begin
    opnd    = (op == OP_R) ? b : imm_ext;
    lt      = $signed(a) < $signed(opnd);
    alu_res = '0;
    unique case (op)
      OP_R: begin
        unique case (funct)
          3'd0: alu_res = a + b;
          3'd1: alu_res = a - b;
          3'd2: alu_res = a & b;
          3'd3: alu_res = a | b;
          3'd4: alu_res = {{(DATA_W-1){1'b0}}, lt};
          3'd5: alu_res = ~(a | b);
          3'd6: alu_res = a << b[SH_W-1:0];
          3'd7: alu_res = a >> b[SH_W-1:0];
          default: alu_res = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_res = a + imm_ext;
      OP_ANDI:        alu_res = a & imm_ext;
      OP_ORI:         alu_res = a | imm_ext;
      OP_BEQ, OP_BNE: alu_res = a - b;
      OP_SLTI: alu_res = {{(DATA_W-1){1'b0}}, lt};
      default:        alu_res = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:  if (instr_valid) state_nx = S_DECODE;
      S_DECODE: state_nx = legal ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (is_br)       state_nx = S_FETCH;
        else if (is_mem) state_nx = S_MEM;
        else             state_nx = S_WB;
      end
      S_MEM:   state_nx = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:    state_nx = S_FETCH;
      default: state_nx = S_FETCH;
    endcase
  end

  // Pulses are masked while rst_n is low so an aborted WB is invisible.
  assign instr_ready  = rst_n && (state == S_FETCH);
  assign illegal      = rst_n && (state == S_DECODE) && !legal;
  assign result_valid = rst_n && (state == S_WB);
  assign result       = result_valid ? wb_val : result_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= '0;
      result_q <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_FETCH: begin
          if (instr_valid) begin
            ir <= instr;
            pc <= pc + PC_W'(1);
          end
        end
        S_DECODE: begin
          a <= rd_rs;
          b <= rd_rt;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (taken) pc <= pc + imm_ext[PC_W-1:0];
        end
        S_MEM: begin
          if (op == OP_LW) mdr <= dmem[maddr];
        end
        S_WB: begin
          result_q <= wb_val;
          if (wb_dst != 3'd0) regs[wb_dst] <= wb_val;
        end
        default: ;
      endcase
    end
  end

  // Data memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (rst_n && (state == S_MEM) && (op == OP_SW))
      dmem[maddr] <= b;
  end

endmodule
